// File: rtl/dbg_pkg.sv
// Shared constants for the debug console: ASCII glyphs and fixed column layout.
package dbg_pkg;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int unsigned COL_HEX_START = 5;
  localparam int unsigned COL_HEX_LEN   = 8;
  localparam int unsigned COL_MARK      = 14;
endpackage

// File: rtl/bin_to_hex_ascii.sv
// Converts one binary nibble to its uppercase ASCII hex character.
module bin_to_hex_ascii (
  input  logic [3:0] bin_i,
  output logic [7:0] ascii_o
);
  always_comb begin
    if (bin_i < 4'd10) ascii_o = 8'h30 + {4'h0, bin_i};
    else               ascii_o = 8'h37 + {4'h0, bin_i};
  end
endmodule

// File: rtl/dbg_console.sv
// Scans a ROWS x COLS text console, rendering one "Rnn: XXXXXXXX" line per watch channel.
// Optional macro DBG_CHANGE_MARK_EN adds a "*" change marker at the mark column.
module dbg_console
  import dbg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   freeze,
  input  logic [NUM_CH*32-1:0]   watch_data,
  output logic [ADDR_W-1:0]      console_addr,
  output logic                   console_write,
  output logic [7:0]             console_data,
  output logic                   frame_done
);
  localparam int unsigned ROW_W = (ROWS > 32) ? $clog2(ROWS) : 5;
  localparam int unsigned COL_W = (COLS > 16) ? $clog2(COLS) : 4;

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] lin_q, lin_d, addr_q;
  logic [7:0]        data_q, char_d;
  logic              wr_q, fd_q;
  logic [31:0]       snap_q [NUM_CH];
`ifdef DBG_CHANGE_MARK_EN
  logic [31:0]       prev_q [NUM_CH];
  logic              changed;
`endif

  logic              col_last, row_last, in_ch;
  logic [31:0]       snap_sel;
  logic [ROW_W-1:0]  units;
  logic [7:0]        tens_c;
  logic [COL_W-1:0]  hex_off;
  logic [3:0]        nib;
  logic [7:0]        hex_c;

  bin_to_hex_ascii u_hex (
    .bin_i   (nib),
    .ascii_o (hex_c)
  );

  // Linear address tracks row*COLS+col incrementally, avoiding a multiplier.
  always_comb begin
    col_last = (col_q == COL_W'(COLS - 1));
    row_last = (row_q == ROW_W'(ROWS - 1));
    col_d = col_q;
    row_d = row_q;
    lin_d = lin_q;
    if (enable) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      lin_d = (col_last && row_last) ? '0 : lin_q + 1'b1;
    end
  end

  always_comb begin
    in_ch    = (row_q < ROW_W'(NUM_CH));
    snap_sel = '0;
`ifdef DBG_CHANGE_MARK_EN
    changed  = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (row_q == ROW_W'(i)) begin
        snap_sel = snap_q[i];
`ifdef DBG_CHANGE_MARK_EN
        changed  = (prev_q[i] != snap_q[i]);
`endif
      end
    end

    if (row_q >= ROW_W'(20)) begin
      tens_c = ASCII_ZERO + 8'd2;
      units  = row_q - ROW_W'(20);
    end else if (row_q >= ROW_W'(10)) begin
      tens_c = ASCII_ZERO + 8'd1;
      units  = row_q - ROW_W'(10);
    end else begin
      tens_c = ASCII_ZERO;
      units  = row_q;
    end

    hex_off = COL_W'(COL_HEX_START + COL_HEX_LEN - 1) - col_q;
    nib     = 4'(snap_sel >> {hex_off, 2'b00});

    char_d = '0;
    if (in_ch) begin
      if (col_q == COL_W'(0))      char_d = ASCII_R;
      else if (col_q == COL_W'(1)) char_d = tens_c;
      else if (col_q == COL_W'(2)) char_d = ASCII_ZERO + 8'(units);
      else if (col_q == COL_W'(3)) char_d = ASCII_COLON;
      else if (col_q == COL_W'(4)) char_d = ASCII_SPACE;
      else if (col_q >= COL_W'(COL_HEX_START) &&
               col_q <  COL_W'(COL_HEX_START + COL_HEX_LEN)) char_d = hex_c;
`ifdef DBG_CHANGE_MARK_EN
      else if (col_q == COL_W'(COL_MARK)) char_d = changed ? ASCII_STAR : ASCII_SPACE;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      lin_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      fd_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        snap_q[i] <= '0;
`ifdef DBG_CHANGE_MARK_EN
        prev_q[i] <= '0;
`endif
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      lin_q <= lin_d;
      wr_q  <= enable;
      fd_q  <= enable && col_last && row_last;
      if (enable) begin
        addr_q <= lin_q;
        data_q <= char_d;
      end
      // Cell (0,0) never shows snapshot data, so reloading here keeps the frame coherent.
      if (enable && !freeze && col_q == '0 && row_q == '0) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          snap_q[i] <= watch_data[32*i +: 32];
`ifdef DBG_CHANGE_MARK_EN
          prev_q[i] <= snap_q[i];
`endif
        end
      end
    end
  end

  assign console_addr  = addr_q;
  assign console_write = wr_q;
  assign console_data  = data_q;
  assign frame_done    = fd_q;
endmodule

// File: tb/tb_dbg_console.sv
// Self-checking bench for dbg_console: per-cycle model comparison plus directed literal checks.
module tb_dbg_console;
  localparam int NUM_CH = 4;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int CELLS  = COLS * ROWS;

  logic                 clock = 1'b0;
  logic                 reset_n, enable, freeze;
  logic [NUM_CH*32-1:0] watch;
  logic [ADDR_W-1:0]    console_addr;
  logic                 console_write;
  logic [7:0]           console_data;
  logic                 frame_done;

  int tests  = 0;
  int failed = 0;

  dbg_console #(.NUM_CH(NUM_CH), .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .freeze        (freeze),
    .watch_data    (watch),
    .console_addr  (console_addr),
    .console_write (console_write),
    .console_data  (console_data),
    .frame_done    (frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: linear cell position, snapshot arrays, text built from rules.
  int          m_pos = 0;
  logic [31:0] m_snap [NUM_CH];
  logic [31:0] m_prev [NUM_CH];
  bit          m_valid = 0;
  logic        e_w, e_fd;
  logic [31:0] e_a;
  logic [7:0]  e_d;

  function automatic logic [7:0] m_char(input int r, input int c);
    string hx;
    hx = "0123456789ABCDEF";
    if (r >= NUM_CH) return 8'h00;
    case (c)
      0: return "R";
      1: return 8'(8'h30 + r / 10);
      2: return 8'(8'h30 + r % 10);
      3: return ":";
      4: return " ";
      default: ;
    endcase
    if (c >= 5 && c <= 12) return hx[(m_snap[r] >> (4 * (12 - c))) & 32'hF];
`ifdef DBG_CHANGE_MARK_EN
    if (c == 14) return (m_prev[r] != m_snap[r]) ? "*" : " ";
`endif
    return 8'h00;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      m_pos = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_snap[i] = '0;
        m_prev[i] = '0;
      end
      e_w = 0; e_fd = 0; e_a = 0; e_d = 0;
      m_valid = 1;
    end else if (enable) begin
      if (m_pos == 0 && !freeze)
        for (int i = 0; i < NUM_CH; i++) begin
          m_prev[i] = m_snap[i];
          m_snap[i] = watch[32*i +: 32];
        end
      e_a  = m_pos;
      e_d  = m_char(m_pos / COLS, m_pos % COLS);
      e_w  = 1;
      e_fd = (m_pos == CELLS - 1);
      m_pos = (m_pos + 1) % CELLS;
    end else begin
      e_w = 0;
      e_fd = 0;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_write", console_write, e_w);
      chk("model_frame_done", frame_done, e_fd);
      if (e_w) begin
        chk("model_addr", console_addr, e_a);
        chk("model_data", console_data, e_d);
      end
    end
  end

  // Shadow of the console memory and frame_done bookkeeping.
  logic [7:0] shadow [CELLS];
  int fd_count = 0;
  int fd_addr  = -1;
  always @(negedge clock) begin
    if (console_write === 1'b1 && console_addr < CELLS) shadow[console_addr] = console_data;
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_addr = console_addr;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic clr_shadow();
    for (int i = 0; i < CELLS; i++) shadow[i] = 8'hFF;
  endtask

  task automatic chk_str(input string nm, input int base, input string s);
    for (int i = 0; i < s.len(); i++) chk(nm, shadow[base + i], s[i]);
  endtask

  initial begin
    reset_n = 0; enable = 0; freeze = 0;
    watch = '0;
    watch[31:0] = 32'hDEADBEEF;
    clr_shadow();
    step(2);
    chk("reset_write", console_write, 0);
    chk("reset_addr", console_addr, 0);
    chk("reset_data", console_data, 0);
    chk("reset_frame_done", frame_done, 0);

    // Full frame with enable held high.
    reset_n = 1; enable = 1; fd_count = 0;
    step(CELLS);
    chk("frame_done_count", fd_count, 1);
    chk("frame_done_addr", fd_addr, CELLS - 1);
    chk_str("row0_text", 0, "R00: DEADBEEF");
    chk_str("row1_label", 80, "R01");
    chk("row0_col13", shadow[13], 8'h00);
    chk("row5_blank", shadow[5*COLS + 5], 8'h00);
    step(1);
    chk("wrap_addr", console_addr, 0);
    chk("wrap_write", console_write, 1);

    // Freeze blocks the snapshot reload at frame start.
    watch[63:32] = 32'h12345678;
    step(CELLS - 1);
    freeze = 1;
    step(1);
    freeze = 0;
    clr_shadow();
    step(CELLS - 1);
    chk_str("frozen_row1", 85, "00000000");
    step(1);
    clr_shadow();
    step(CELLS - 1);
    chk_str("thawed_row1", 85, "12345678");

    // Stall for five cycles after addr 100.
    step(101);
    chk("pre_stall_addr", console_addr, 100);
    enable = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("stall_write", console_write, 0);
    end
    enable = 1;
    step(1);
    chk("resume_addr", console_addr, 101);
    chk("resume_write", console_write, 1);

    // Reset mid-frame at addr 1500.
    step(1399);
    chk("pre_reset_addr", console_addr, 1500);
    reset_n = 0;
    step(1);
    chk("midreset_write", console_write, 0);
    chk("midreset_addr", console_addr, 0);
    chk("midreset_data", console_data, 0);
    chk("midreset_fd", frame_done, 0);
    reset_n = 1;
    step(1);
    chk("post_reset_addr", console_addr, 0);
    chk("post_reset_write", console_write, 1);

    // Change marker on channel 2 (mark cell is 8'h00 when the feature is absent).
    watch[95:64] = 32'hA5A5A5A5;
    step(CELLS - 1);
    step(1);
    clr_shadow();
    step(CELLS - 1);
    chk_str("row2_hex", 165, "A5A5A5A5");
`ifdef DBG_CHANGE_MARK_EN
    chk("mark_changed", shadow[174], "*");
`else
    chk("mark_absent", shadow[174], 8'h00);
`endif
    step(1);
    clr_shadow();
    step(CELLS - 1);
`ifdef DBG_CHANGE_MARK_EN
    chk("mark_unchanged", shadow[174], " ");
`else
    chk("mark_absent2", shadow[174], 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/dbg_console.md
DBG_CONSOLE -- requirements
Module: dbg_console

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of 32-bit watch channels, legal 1..30.
REQ-002 SHALL have parameter COLS, default 80: console columns per row.
REQ-003 SHALL have parameter ROWS, default 30: console rows; COLS*ROWS SHALL fit in ADDR_W bits.
REQ-004 SHALL have parameter ADDR_W, default 12: console address width.
REQ-005 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable  in  1  scan advance permission; low stalls the scan.
REQ-008 SHALL have port freeze  in  1  high blocks snapshot refresh at frame start.
REQ-009 SHALL have port watch_data  in  NUM_CH*32  channel i occupies bits [32*i+31:32*i].
REQ-010 SHALL have port console_addr  out  ADDR_W  registered write address.
REQ-011 SHALL have port console_write  out  1  registered write strobe.
REQ-012 SHALL have port console_data  out  8  registered ASCII character.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse when the last cell is written.

Function
REQ-014 SHALL keep internal scan position (row, col), with col incrementing 0..COLS-1; wrap to 0 increments row; row ROWS-1, col COLS-1 wraps to (0,0); no multiplier.
REQ-015 SHALL advance the position only on cycles where enable=1; with enable=0 the position holds and console_write SHALL be 0 next cycle.
REQ-016 SHALL, on an enabled cycle, register console_addr=row*COLS+col, console_data=char(row,col), console_write=1 (latency 1 cycle).
REQ-017 SHALL produce char for row r<NUM_CH as: col0 "R"; col1 tens digit of r; col2 units digit of r; col3 ":"; col4 " "; col5..12 hex nibbles of snapshot[r] MSB first, uppercase; all other cells 8'h00.
REQ-018 SHALL write 8'h00 to every cell of rows r>=NUM_CH.
REQ-019 SHALL, on an enabled cycle at position (0,0) with freeze=0, load snapshot[i]<=watch_data channel i for all i; with freeze=1, snapshot holds.
REQ-020 SHALL use the snapshot value throughout a frame, so one frame shows one coherent sample.
REQ-021 SHALL pulse frame_done=1 in the same cycle console_addr=COLS*ROWS-1 is presented with console_write=1; otherwise 0.
REQ-022 SHALL accept enable toggling at any position without skipping or repeating cells.

Reset
REQ-023 SHALL, when reset_n=0 at a rising edge: position (0,0); console_addr=0; console_data=0; console_write=0; frame_done=0; all snapshot and previous-snapshot registers 0.
REQ-024 SHALL restart from (0,0) after reset mid-frame; the first enabled cycle after release emits address 0.

Configuration
REQ-025 SHALL, with macro DBG_CHANGE_MARK_EN defined, keep prev[i], load prev[i]<=snapshot[i] at each snapshot load, and write "*" at col 14 of row i when prev[i]!=snapshot[i], else " ".
REQ-026 SHALL, without DBG_CHANGE_MARK_EN, omit prev registers and write 8'h00 at col 14.

Structure
REQ-027 SHALL take ASCII constants (R, colon, space, asterisk) and column indices (hex start 5, mark 14) from shared package dbg_pkg.
REQ-028 SHALL instantiate the existing bin_to_hex_ascii sub-module for nibble-to-ASCII conversion; no other sub-module.

Verification
REQ-029 SHALL check: reset, enable=1, NUM_CH=4, ch0=32'hDEADBEEF -> addr 0..12 give "R00: DEADBEEF", addr 80 gives "R", addr 81..82 "01".
REQ-030 SHALL check: enable held 1 for 2400 cycles -> frame_done exactly once at addr 2399, next addr 0.
REQ-031 SHALL check: freeze=1 at frame start, ch1 changed 0->32'h12345678 -> row 1 still shows "00000000"; after freeze=0 next frame shows "12345678".
REQ-032 SHALL check: enable low 5 cycles at addr 100 -> console_write 0 for 5 cycles, resumes at addr 101 with no gap.
REQ-033 SHALL check: reset_n=0 at addr 1500 -> outputs 0 next cycle, first write after release is addr 0.
REQ-034 SHALL check (DBG_CHANGE_MARK_EN): ch2 changes between frames -> addr 174 is "*"; unchanged next frame -> " ".
